addsub_seq_ctrl: RTL

//   Sequencer that computes a wide (N*WORDS-bit) add or subtract using one external
//   N-bit adder_subtractor slice, processing one slice per clock, LSB first.
//   The carry is chained through an internal register between slices.

---
 rtl/addsub_seq_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/addsub_seq_ctrl.sv
// Sequencer for an N*WORDS-bit add/subtract over one external N-bit adder_subtractor slice.
// Optional abort input enabled by defining ADDSUB_SEQ_ABORT_EN.
module addsub_seq_ctrl #(
   parameter int N     = 4,
   parameter int WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 op_sub,
   input  logic [N*WORDS-1:0]   op_a,
   input  logic [N*WORDS-1:0]   op_b,
`ifdef ADDSUB_SEQ_ABORT_EN
   input  logic                 abort,
`endif
   output logic                 ready,
   output logic                 done,
   output logic [N*WORDS-1:0]   result,
   output logic                 carry_out,
   output logic                 overflow,
   output logic [N-1:0]         dp_a,
   output logic [N-1:0]         dp_b,
   output logic                 dp_cin,
   input  logic [N-1:0]         dp_s,
   input  logic                 dp_cout,
   input  logic                 dp_ovf
);

   localparam int W  = N * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state;
   logic [IW-1:0] idx;
   logic [W-1:0]  a_r;
   logic [W-1:0]  b_r;
   logic          sub_r;
   logic          carry;
   logic          abort_req;

`ifdef ADDSUB_SEQ_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   assign ready = (state == IDLE);
   assign done  = (state == DONE);

   // The slice adder inverts b and adds 1 whenever cin=1, so b is pre-inverted
   // by (op_sub ^ carry) to make it compute a_k + (sub ? ~b_k : b_k) + carry.
   always_comb begin
      dp_a   = '0;
      dp_b   = '0;
      dp_cin = 1'b0;
      if (state == RUN) begin
         dp_a   = a_r[int'(idx)*N +: N];
         dp_b   = b_r[int'(idx)*N +: N] ^ {N{sub_r ^ carry}};
         dp_cin = carry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         a_r       <= '0;
         b_r       <= '0;
         sub_r     <= 1'b0;
         carry     <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_r   <= op_a;
                  b_r   <= op_b;
                  sub_r <= op_sub;
                  idx   <= '0;
                  carry <= op_sub;
                  state <= RUN;
               end
            end
            RUN: begin
               if (abort_req) begin
                  state <= IDLE;
               end else begin
                  result[int'(idx)*N +: N] <= dp_s;
                  carry <= dp_cout;
                  idx   <= idx + 1'b1;
                  if (idx == LAST) begin
                     carry_out <= dp_cout;
                     overflow  <= dp_ovf;
                     state     <= DONE;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
